// File: rtl/encoder_pkg.sv
// encoder_pkg: shared definitions for the quadrature encoder front end.
//   - Gray-state constants for the {A,B} pin pair
//   - direction type for the per-channel dir output
//   - legal RESOLUTION values (counted edges per Gray cycle)
//   - gray_next_up(): successor of a state in the up sequence
package encoder_pkg;

    localparam logic [1:0] ST_00 = 2'b00;
    localparam logic [1:0] ST_10 = 2'b10;
    localparam logic [1:0] ST_11 = 2'b11;
    localparam logic [1:0] ST_01 = 2'b01;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    localparam int RES_X1 = 1;
    localparam int RES_X2 = 2;
    localparam int RES_X4 = 4;

    // Up sequence is 00 -> 10 -> 11 -> 01 -> 00; down is the reverse,
    // so "s moved down to t" is the same as gray_next_up(t) == s.
    function automatic logic [1:0] gray_next_up(input logic [1:0] s);
        logic [1:0] n;
        case (s)
            ST_00:   n = ST_10;
            ST_10:   n = ST_11;
            ST_11:   n = ST_01;
            default: n = ST_00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/quad_encoder_array_if.sv
// quad_encoder_array_if: pin and result bundle of the encoder array.
//   a, b    raw asynchronous encoder pins, one bit per channel
//   clr     synchronous per-channel position clear
//   value   packed positions, channel i at [i*WIDTH +: WIDTH]
//   step    one-cycle pulse per counted step
//   dir     direction of the last counted step (1 = up)
//   err     sticky illegal-transition flag
// master = pin/consumer side, slave = the encoder array.
interface quad_encoder_array_if #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8
);
    logic [CHANNELS-1:0]       a;
    logic [CHANNELS-1:0]       b;
    logic [CHANNELS-1:0]       clr;
    logic [CHANNELS*WIDTH-1:0] value;
    logic [CHANNELS-1:0]       step;
    logic [CHANNELS-1:0]       dir;
    logic [CHANNELS-1:0]       err;

    modport master (output a, b, clr, input value, step, dir, err);
    modport slave  (input a, b, clr, output value, step, dir, err);
endinterface

// File: rtl/encoder_channel.sv
// encoder_channel: one quadrature channel.
//   2-flop synchroniser per pin -> debounce filter -> Gray decode -> position.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   a_raw, b_raw      asynchronous encoder pins
//   clr               synchronous clear of value (and err)
//   value             position register
//   step              pulse on the cycle value took a counted step
//   dir               direction of last counted step, held
//   err               sticky illegal-transition flag (ENCODER_ERROR_EN), else 0
// Build option: ENCODER_ERROR_EN enables the illegal-transition flag.
module encoder_channel
    import encoder_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int INC_VALUE  = 1,
    parameter int DEBOUNCE   = 3,
    parameter int RESOLUTION = 2,
    parameter int SATURATE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_raw,
    input  logic             b_raw,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             step,
    output logic             dir,
    output logic             err
);

    localparam int            CW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'((DEBOUNCE > 0) ? DEBOUNCE - 1 : 0);
    localparam logic [WIDTH:0] INC_EXT = (WIDTH + 1)'(INC_VALUE);

    // Pin vectors are ordered {A,B} to match the Gray-state constants.
    logic [1:0]          sync1_q, sync1_d;
    logic [1:0]          sync2_q, sync2_d;
    logic [1:0]          filt_q, filt_d;
    logic [1:0][CW-1:0]  cnt_q, cnt_d;
    logic [1:0]          prev_q, prev_d;
    logic [WIDTH-1:0]    value_q, value_d;
    logic                step_q, step_d;
    dir_e                dir_q, dir_d;

    logic [1:0]          cur;
    logic                leave_ok;
    logic                count_up;
    logic                count_dn;
    logic [WIDTH:0]      sum_up;
    logic [WIDTH:0]      diff_dn;

    // Debounce: the counter tracks consecutive cycles of disagreement and the
    // filtered pin flips when it reaches DEBOUNCE; any agreement restarts it.
    always_comb begin
        sync1_d = {a_raw, b_raw};
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = cnt_q;
        for (int p = 0; p < 2; p++) begin
            if (sync2_q[p] == filt_q[p]) begin
                cnt_d[p] = '0;
            end else if (cnt_q[p] == DB_LAST) begin
                filt_d[p] = sync2_q[p];
                cnt_d[p]  = '0;
            end else begin
                cnt_d[p] = cnt_q[p] + 1'b1;
            end
        end
    end

    // DEBOUNCE = 0 bypasses the filter entirely.
    assign cur = (DEBOUNCE == 0) ? sync2_q : filt_q;

    always_comb begin
        case (RESOLUTION)
            RES_X4:  leave_ok = 1'b1;
            RES_X2:  leave_ok = (prev_q == ST_00) || (prev_q == ST_11);
            default: leave_ok = (prev_q == ST_00);
        endcase
        count_up = (cur == gray_next_up(prev_q)) && leave_ok;
        count_dn = (prev_q == gray_next_up(cur)) && leave_ok;
    end

    // Extra top bit gives the carry (up) or borrow (down) used for clamping.
    always_comb begin
        sum_up  = {1'b0, value_q} + INC_EXT;
        diff_dn = {1'b0, value_q} - INC_EXT;
        prev_d  = cur;
        value_d = value_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
        if (clr) begin
            value_d = '0;
        end else if (count_up) begin
            step_d  = 1'b1;
            dir_d   = DIR_UP;
            value_d = (SATURATE != 0 && sum_up[WIDTH]) ? {WIDTH{1'b1}} : sum_up[WIDTH-1:0];
        end else if (count_dn) begin
            step_d  = 1'b1;
            dir_d   = DIR_DOWN;
            value_d = (SATURATE != 0 && diff_dn[WIDTH]) ? '0 : diff_dn[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            cnt_q   <= '0;
            prev_q  <= ST_00;
            value_q <= '0;
            step_q  <= 1'b0;
            dir_q   <= DIR_DOWN;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            value_q <= value_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
        end
    end

    assign value = value_q;
    assign step  = step_q;
    assign dir   = dir_q;

`ifdef ENCODER_ERROR_EN
    logic err_q, err_d;
    logic illegal;

    // Both bits changing at once skips a Gray state: direction is unknowable.
    assign illegal = &(cur ^ prev_q);

    always_comb begin
        err_d = clr ? 1'b0 : (err_q | illegal);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/quad_encoder_array.sv
// quad_encoder_array: CHANNELS independent quadrature encoder counters.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    quad_encoder_array_if.slave: a/b/clr in, value/step/dir/err out
// Build option: ENCODER_ERROR_EN enables the per-channel err flag
// (inside encoder_channel); otherwise err reads 0.
module quad_encoder_array
    import encoder_pkg::*;
#(
    parameter int CHANNELS   = 3,
    parameter int WIDTH      = 8,
    parameter int INC_VALUE  = 1,
    parameter int DEBOUNCE   = 3,
    parameter int RESOLUTION = RES_X2,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    quad_encoder_array_if.slave   bus
);

    logic [WIDTH-1:0]    val_w [CHANNELS];
    logic [CHANNELS-1:0] step_w;
    logic [CHANNELS-1:0] dir_w;
    logic [CHANNELS-1:0] err_w;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        encoder_channel #(
            .WIDTH      (WIDTH),
            .INC_VALUE  (INC_VALUE),
            .DEBOUNCE   (DEBOUNCE),
            .RESOLUTION (RESOLUTION),
            .SATURATE   (SATURATE)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .a_raw (bus.a[i]),
            .b_raw (bus.b[i]),
            .clr   (bus.clr[i]),
            .value (val_w[i]),
            .step  (step_w[i]),
            .dir   (dir_w[i]),
            .err   (err_w[i])
        );
    end

    always_comb begin
        bus.value = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.value[i*WIDTH +: WIDTH] = val_w[i];
        end
    end

    assign bus.step = step_w;
    assign bus.dir  = dir_w;
    assign bus.err  = err_w;

endmodule

// File: tb/tb_quad_encoder_array.sv
// Bench for quad_encoder_array: two instances with different configurations,
// a Gray-phase reference model, and a step-driven scoreboard.
module tb_quad_encoder_array;

    // Configuration of the two instances: index 0 = dut0, 1 = dut1
    localparam int CFG_CH[2]  = '{3, 2};
    localparam int CFG_INC[2] = '{1, 4};
    localparam int CFG_DB[2]  = '{3, 0};
    localparam int CFG_RES[2] = '{2, 4};
    localparam int CFG_SAT[2] = '{0, 1};
    localparam int MAXV       = 255;

    typedef struct {
        int val;
        int dir;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    quad_encoder_array_if #(.CHANNELS(3), .WIDTH(8)) ifa ();
    quad_encoder_array_if #(.CHANNELS(2), .WIDTH(8)) ifb ();

    quad_encoder_array #(
        .CHANNELS(3), .WIDTH(8), .INC_VALUE(1), .DEBOUNCE(3), .RESOLUTION(2), .SATURATE(0)
    ) u_dut0 (.clk(clk), .reset(reset), .bus(ifa));

    quad_encoder_array #(
        .CHANNELS(2), .WIDTH(8), .INC_VALUE(4), .DEBOUNCE(0), .RESOLUTION(4), .SATURATE(1)
    ) u_dut1 (.clk(clk), .reset(reset), .bus(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state, indexed [dut][channel]
    int   m_phase [2][3];   // position in Gray cycle: 0=00 1=10 2=11 3=01
    int   m_val   [2][3];
    int   m_dir   [2][3];
    int   m_err   [2][3];
    exp_t exp_q   [6][$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int out_val(input int d, input int ch);
        if (d == 0) return int'(ifa.value[ch*8 +: 8]);
        return int'(ifb.value[ch*8 +: 8]);
    endfunction

    function automatic int out_dir(input int d, input int ch);
        if (d == 0) return int'(ifa.dir[ch]);
        return int'(ifb.dir[ch]);
    endfunction

    function automatic int out_err(input int d, input int ch);
        if (d == 0) return int'(ifa.err[ch]);
        return int'(ifb.err[ch]);
    endfunction

    function automatic int exp_err(input int d, input int ch);
`ifdef ENCODER_ERROR_EN
        return m_err[d][ch];
`else
        return 0 * m_err[d][ch];
`endif
    endfunction

    function automatic logic [1:0] pins_of(input int ph);
        case (ph % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic set_pins(input int d, input int ch, input logic [1:0] ab);
        if (d == 0) begin
            ifa.a[ch] = ab[1];
            ifa.b[ch] = ab[0];
        end else begin
            ifb.a[ch] = ab[1];
            ifb.b[ch] = ab[0];
        end
    endtask

    task automatic set_clr(input int d, input int ch, input logic v);
        if (d == 0) ifa.clr[ch] = v;
        else        ifb.clr[ch] = v;
    endtask

    // Move channel by delta phases (1 up, 3 down, 2 illegal) at current cycle.
    // clr_hit: a clear lands on the same cycle as this step's update.
    task automatic move(input int d, input int ch, input int delta, input bit clr_hit);
        int   op;
        bit   counted;
        int   v;
        exp_t e;
        op = m_phase[d][ch];
        m_phase[d][ch] = (op + delta) % 4;
        set_pins(d, ch, pins_of(m_phase[d][ch]));
        if (delta == 2) begin
            m_err[d][ch] = 1;
            return;
        end
        counted = (CFG_RES[d] == 4) || (CFG_RES[d] == 2 && op % 2 == 0) ||
                  (CFG_RES[d] == 1 && op == 0);
        if (!counted) return;
        if (clr_hit) begin
            m_val[d][ch] = 0;
            return;
        end
        v = m_val[d][ch];
        if (delta == 1) begin
            v = v + CFG_INC[d];
            if (v > MAXV) v = (CFG_SAT[d] != 0) ? MAXV : v - (MAXV + 1);
            m_dir[d][ch] = 1;
        end else begin
            v = v - CFG_INC[d];
            if (v < 0) v = (CFG_SAT[d] != 0) ? 0 : v + (MAXV + 1);
            m_dir[d][ch] = 0;
        end
        m_val[d][ch] = v;
        e.val = v;
        e.dir = m_dir[d][ch];
        e.cyc = cyc + 3 + CFG_DB[d];
        exp_q[d*3+ch].push_back(e);
    endtask

    task automatic model_clr(input int d, input int ch);
        m_val[d][ch] = 0;
        m_err[d][ch] = 0;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < 3; ch++) begin
                m_phase[d][ch] = 0;
                m_val[d][ch]   = 0;
                m_dir[d][ch]   = 0;
                m_err[d][ch]   = 0;
            end
        for (int i = 0; i < 6; i++) exp_q[i].delete();
    endtask

    task automatic check_all(input string tag);
        for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < CFG_CH[d]; ch++) begin
                check($sformatf("%s_d%0d_ch%0d_value", tag, d, ch), out_val(d, ch), m_val[d][ch]);
                check($sformatf("%s_d%0d_ch%0d_dir", tag, d, ch), out_dir(d, ch), m_dir[d][ch]);
                check($sformatf("%s_d%0d_ch%0d_err", tag, d, ch), out_err(d, ch), exp_err(d, ch));
                check($sformatf("%s_d%0d_ch%0d_pending", tag, d, ch), exp_q[d*3+ch].size(), 0);
            end
    endtask

    task automatic check_step(input int d, input int ch);
        exp_t e;
        int   idx;
        idx = d*3 + ch;
        if (exp_q[idx].size() == 0) begin
            check($sformatf("d%0d_ch%0d_unexpected_step", d, ch), 1, 0);
            return;
        end
        e = exp_q[idx].pop_front();
        check($sformatf("d%0d_ch%0d_step_value", d, ch), out_val(d, ch), e.val);
        check($sformatf("d%0d_ch%0d_step_dir", d, ch), out_dir(d, ch), e.dir);
        check($sformatf("d%0d_ch%0d_step_cycle", d, ch), cyc, e.cyc);
    endtask

    // Monitor: every step pulse must match the oldest expected update
    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < 3; c++) if (ifa.step[c]) check_step(0, c);
            for (int c = 0; c < 2; c++) if (ifb.step[c]) check_step(1, c);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int act [2][3];
        ifa.a = '0; ifa.b = '0; ifa.clr = '0;
        ifb.a = '0; ifb.b = '0; ifb.clr = '0;
        model_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);
        check_all("reset");

        // Full up Gray cycle on dut0 ch0: two counted steps at x2
        for (int i = 0; i < 4; i++) begin
            move(0, 0, 1, 0);
            tick(8);
        end
        check_all("upcycle");

        // Down from 0 wraps to 255, then back up across the boundary
        move(0, 1, 3, 0);
        tick(8);
        check_all("wrap_down");
        move(0, 1, 1, 0); tick(8);
        move(0, 1, 1, 0); tick(8);
        check_all("wrap_up");

        // 2-cycle glitch is filtered; 3-cycle pulse counts once (return leaves 10)
        set_pins(0, 2, 2'b10);
        tick(2);
        set_pins(0, 2, 2'b00);
        tick(10);
        check_all("glitch");
        move(0, 2, 1, 0);
        tick(3);
        move(0, 2, 3, 0);
        tick(12);
        check_all("pulse3");

        // ch0 steps normally, ch2 steps down while clr lands on its update cycle
        move(0, 0, 1, 0);
        move(0, 2, 3, 1);
        tick(2 + CFG_DB[0]);
        set_clr(0, 2, 1'b1);
        tick(1);
        set_clr(0, 2, 1'b0);
        tick(6);
        check_all("clr_coincide");

        // Reset in the middle of a debounce: pending edge must be lost
        set_pins(0, 1, 2'b01);
        tick(2);
        reset = 1'b1;
        ifa.a = '0; ifa.b = '0;
        model_reset();
        tick(2);
        check_all("in_reset");
        reset = 1'b0;
        tick(12);
        check_all("post_reset");

        // Saturation on dut1 (x4, INC 4): climb to 255, stay, then clamp at 0
        for (int i = 0; i < 66; i++) begin
            move(1, 0, 1, 0);
            tick(3);
        end
        tick(3);
        check_all("sat_hi");
        for (int i = 0; i < 66; i++) begin
            move(1, 0, 3, 0);
            tick(3);
        end
        tick(3);
        check_all("sat_lo");

        // Illegal 00 -> 11 jump: no count, err (when enabled); clr clears both
        move(0, 0, 2, 0);
        tick(8);
        check_all("illegal");
        set_clr(0, 0, 1'b1);
        model_clr(0, 0);
        tick(1);
        set_clr(0, 0, 1'b0);
        tick(2);
        check_all("illegal_clr");

        // Randomised traffic on all channels of both instances
        for (int it = 0; it < 200; it++) begin
            for (int d = 0; d < 2; d++)
                for (int ch = 0; ch < CFG_CH[d]; ch++) begin
                    act[d][ch] = int'($urandom_range(0, 9));
                    case (act[d][ch])
                        1, 2, 3: move(d, ch, 1, 0);
                        4, 5, 6: move(d, ch, 3, 0);
                        7:       move(d, ch, 2, 0);
                        8: begin
                            set_clr(d, ch, 1'b1);
                            model_clr(d, ch);
                        end
                        default: ;
                    endcase
                end
            tick(1);
            ifa.clr = '0;
            ifb.clr = '0;
            tick(11);
            if (it % 20 == 19) check_all($sformatf("rand%0d", it));
        end

        tick(10);
        check_all("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/quad_encoder_array.md
# quad_encoder_array

Multi-channel quadrature rotary-encoder front end: one independent position counter per channel, driven by raw asynchronous A/B pins. Each channel synchronises and debounces its pins, decodes Gray-code steps at x1/x2/x4 resolution, and updates an unsigned position register that either wraps or saturates. The block sits between the board-level encoder pins and the consumer logic (PWM/colour mixers, menus), which reads the `value` bus and the per-channel `step` strobes.

## Interface
- `CHANNELS`, default 3: number of independent encoders.
- `WIDTH`, default 8: position register width per channel.
- `INC_VALUE`, default 1: amount added or subtracted per counted step (must be < 2^WIDTH).
- `DEBOUNCE`, default 3: consecutive stable cycles required before a filtered pin changes; 0 = filter bypassed.
- `RESOLUTION`, default 2: counted edges per Gray cycle, legal values 1, 2 or 4.
- `SATURATE`, default 0: 0 = wrap modulo 2^WIDTH; 1 = clamp at 0 and 2^WIDTH-1.

Ports:
- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high reset.
- `a`  in  CHANNELS  raw A pins, asynchronous.
- `b`  in  CHANNELS  raw B pins, asynchronous.
- `clr`  in  CHANNELS  synchronous per-channel zeroing of `value`.
- `value`  out  CHANNELS*WIDTH  positions; channel i occupies bits [i*WIDTH +: WIDTH].
- `step`  out  CHANNELS  one-cycle pulse on the cycle `value[i]` was updated by a counted step.
- `dir`  out  CHANNELS  direction of the last counted step (1 = up), held between steps.
- `err`  out  CHANNELS  sticky illegal-transition flag (see Configuration).

## Operation
- Per channel, per pin: 2-flop synchroniser, then debounce. The filtered pin takes the synchronised level once that level has differed from the filtered level for DEBOUNCE consecutive cycles. Any agreement resets the counter.
- Decode compares the filtered state {A,B} with the registered previous state. Up sequence: 00→10→11→01→00. Down sequence is the reverse.
- RESOLUTION 4: count every legal single-bit change.
- RESOLUTION 2: count only changes leaving states 00 or 11.
- RESOLUTION 1: count only changes leaving state 00.
- Illegal change (both bits differ): no count, no `step`. The previous state still updates.
- Count up: value + INC_VALUE. Count down: value − INC_VALUE.
  - SATURATE=0: result wraps modulo 2^WIDTH.
  - SATURATE=1: clamps to 2^WIDTH-1 or to 0 if the step would cross. `step` still pulses, even when the clamped value is unchanged.
- Priority per channel: `reset` > `clr[i]` > counted step. When `clr[i]` coincides with a step: value = 0, `step` = 0, `dir` unchanged.
- Reset values:
  - All outputs 0: `value`, `step`, `dir`, `err`.
  - Synchronisers, filtered pins, previous state and debounce counters all 0.
  - First activity after reset is therefore decoded from state 00.

## Timing
- A raw level change, stable from clock edge n, appears on the synchroniser output at edge n+1.
- With DEBOUNCE=D≥1, the filtered pin changes at edge n+1+D, and `value`, `step` and `dir` update at edge n+2+D.
- With D=0, `value` updates at edge n+2.
- Maximum counted rate: one step per channel per 1+max(D,1) cycles. Faster toggling is filtered out, not queued.
- Reset asserted mid-debounce or mid-sequence discards all in-flight state on that edge.

## Configuration
- `ENCODER_ERROR_EN` defined:
  - `err[i]` sets on the cycle after an illegal filtered transition on channel i.
  - It stays set until `clr[i]` or `reset`.
  - If set and cleared in the same cycle, clear wins.
- `ENCODER_ERROR_EN` undefined:
  - `err` is tied to 0 and the detection logic is absent.
  - Illegal transitions are still ignored for counting.

## Structure
- Package `encoder_pkg` holds:
  - Gray-state constants (`ST_00`, `ST_10`, `ST_11`, `ST_01`).
  - The direction typedef (`DIR_DOWN`/`DIR_UP`).
  - Legal RESOLUTION values.
- Sub-module `encoder_channel` holds the synchroniser, debounce and decode/counter logic for one channel. The top level generates it CHANNELS times and packs the outputs.

## Test plan
- WIDTH=8, RESOLUTION=2, D=3, one full up Gray cycle on channel 0 → `value[0]` = 2, two `step` pulses, `dir` = 1; each update 5 cycles after the pin change.
- RESOLUTION=4, SATURATE=0, start 0, one down step with INC_VALUE=1 → `value` = 255, `dir` = 0; then four up steps → 3.
- SATURATE=1, INC_VALUE=4, value 253, one up step → 255 with `step` pulse; another up step → stays 255, `step` pulses.
- D=3: pulse A for 2 cycles (glitch) → no change on filtered pin, `value` or `step`; 3-cycle pulse → counted.
- Drive 00→11 in one cycle with `ENCODER_ERROR_EN` → no count, `err` = 1; `clr[0]` → `err` = 0 and `value` = 0. Without the macro → `err` stays 0.
- Step on channels 0 and 2 with `clr[2]` in the same cycle, then `reset` mid-debounce → ch0 counts and ch2 = 0, `step[2]` = 0; after reset all outputs 0 and pending edges are lost.
